rx_multilane_deskew: RTL and testbench
======================================

# rx_multilane_deskew

Parametrised multi-lane deskew engine for the RX second half. It sits between the per-lane elastic buffers and the descramblers, on the local clock domain. It measures inter-lane skew from per-lane alignment markers (first symbol of an ordered set) and delays each early lane through its own circular buffer so that all active lanes present the same symbol time together. It generalises the fixed 32-lane deskew with three additions: configurable lane count and skew depth, a runtime lane mask for reduced link width, and continuous alignment checking with automatic re-search.

## Interface
Parameters:
- NUM_LANES, 16, number of physical lanes
- SYMBOL_WIDTH, 8, bits per lane symbol
- MAX_SKEW, 8, buffer depth per lane; maximum correctable skew is MAX_SKEW-1 valid cycles
- DLY_WIDTH, $clog2(MAX_SKEW), width of per-lane delay value

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - local_clk, in, 1, local clock
  - local_rst, in, 1, asynchronous active-low reset
- soft_rst, in, 1, synchronous soft reset, equivalent to local_rst
- deskew_en, in, 1, LTSSM request to acquire and hold alignment
- lane_mask, in, NUM_LANES, 1 = lane active; sampled on IDLE→SEARCH
- in_valid, in, 1, common symbol strobe from the elastic buffers
- in_data, in, NUM_LANES*SYMBOL_WIDTH, lane i at bits [i*SYMBOL_WIDTH +: SYMBOL_WIDTH]
- in_sync, in, NUM_LANES, per-lane block-type bit, carried alongside the data
- in_marker, in, NUM_LANES, per-lane alignment-marker flag
- out_valid, out, 1, deskewed symbol strobe
- out_data, out, NUM_LANES*SYMBOL_WIDTH, deskewed data; masked lanes are 0
- out_sync, out, NUM_LANES, deskewed sync bits; masked lanes are 0
- aligned, out, 1, high while in ALIGNED
- deskew_error, out, 1, one-cycle pulse on skew overflow or alignment loss
- lane_delay, out, NUM_LANES*DLY_WIDTH, applied delay per lane

## Operation
- FSM: IDLE, SEARCH, ALIGNED, ERROR.
- IDLE:
  - buffers keep writing; outputs stay 0.
  - On deskew_en=1: latch lane_mask, clear arrival flags and the skew counter, go to SEARCH.
- SEARCH: counts in valid cycles only; cycles with in_valid=0 are ignored.
  - The first in_valid cycle with a marker on any active lane starts the skew counter at 0.
  - Each active lane records the counter value at its first marker as offset_i and sets its arrival flag.
  - When all active lanes have arrived: delay_i = cnt_last − offset_i, where cnt_last is the counter value at the final arrival. Go to ALIGNED.
  - If the counter reaches MAX_SKEW before all active lanes have arrived: go to ERROR.
  - If all lanes arrive in the same cycle, every delay is 0.
- ALIGNED:
  - Lane i output = symbol written delay_i valid cycles earlier; delay 0 bypasses the current input.
  - Checking: if any active lane's delayed marker is asserted while another active lane's delayed marker is not, go to ERROR.
  - deskew_en=0 returns to IDLE.
- ERROR:
  - Pulse deskew_error for one cycle, clear aligned.
  - Next state is SEARCH if deskew_en=1, otherwise IDLE.
- Buffer write pointer advances on in_valid in every state and wraps modulo MAX_SKEW. Read address = (wr_ptr − delay_i) mod MAX_SKEW.
- Masked lanes: excluded from arrival and check logic; delay reported as 0; output forced to 0.
- lane_mask changes outside IDLE are ignored until the next SEARCH entry.

## Timing
- All outputs are registered. Reset values: out_valid, out_data, out_sync, aligned, deskew_error and lane_delay are all 0; state is IDLE; pointers are 0.
- Latency from in_valid to out_valid is 1 cycle. Lane i data latency is 1 cycle + delay_i valid cycles.
- aligned rises 1 cycle after the final marker arrival. lane_delay updates on that same edge.
- deskew_error pulses 1 cycle after the overflow or mismatch is detected.
- soft_rst or local_rst mid-operation clears everything in the same edge (soft_rst) or immediately (local_rst). No partial output is produced.
- A marker arriving on the same cycle the counter would reach MAX_SKEW counts as arrived; no error is raised.

## Structure
- Package rx_deskew_pkg holds:
  - the state enum deskew_state_e (IDLE, SEARCH, ALIGNED, ERROR);
  - the localparam function for DLY_WIDTH.
- Sub-module rx_deskew_lane_buf is instantiated NUM_LANES times in a generate loop. Each instance contains:
  - a circular buffer of MAX_SKEW × (SYMBOL_WIDTH+2) holding {marker, sync, data};
  - the offset register and arrival flag;
  - the read mux with delay-0 bypass.
- The top level holds the FSM, the skew counter, the common write pointer and the output registers.

## Test plan
All scenarios use NUM_LANES=4, MAX_SKEW=8.
1. Zero skew: markers on all 4 lanes in the same valid cycle → aligned after 1 cycle; lane_delay all 0; out_data equals in_data delayed 1 cycle.
2. Skew 0/2/5/3 valid cycles on lanes 0–3 → lane_delay = 5/3/0/2; on the next ordered set, all delayed markers coincide on out.
3. Lane 2 marker arrives 8 cycles after the first → deskew_error pulses once; re-enters SEARCH; succeeds on the next ordered set with skew 1 → aligned.
4. lane_mask=4'b0011, lanes 2–3 never send markers → aligned once lanes 0 and 1 arrive; out_data lanes 2–3 are 0.
5. In ALIGNED, inject a lane-1 marker one cycle late → deskew_error pulses; aligned=0; re-search succeeds.
6. in_valid gapped 1-of-3 during SEARCH with skew 3 → delay still 3. Assert local_rst mid-SEARCH → all outputs 0 and state IDLE.

Source files
------------

// File: rtl/rx_deskew_pkg.sv
// Shared types and sizing helpers for the multi-lane RX deskew engine.
package rx_deskew_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEARCH  = 2'd1,
      ALIGNED = 2'd2,
      ERROR   = 2'd3
   } deskew_state_e;

   // Width of a per-lane delay / buffer pointer; never narrower than one bit.
   function automatic int dly_width(input int max_skew);
      return (max_skew > 1) ? $clog2(max_skew) : 1;
   endfunction

endpackage

// File: rtl/rx_deskew_lane_buf.sv
// One lane of the deskew engine: circular symbol buffer, marker arrival
// tracking during search, and the delayed read with a zero-delay bypass.
module rx_deskew_lane_buf
   import rx_deskew_pkg::*;
#(
   parameter int SYMBOL_WIDTH = 8,
   parameter int MAX_SKEW     = 8,
   parameter int DLY_WIDTH    = dly_width(MAX_SKEW)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    soft_rst,
   input  logic                    wr_en,
   input  logic [DLY_WIDTH-1:0]    wr_ptr,
   input  logic [SYMBOL_WIDTH+1:0] wr_word,
   input  logic                    clr,
   input  logic                    rec_en,
   input  logic [DLY_WIDTH-1:0]    cnt,
   input  logic                    dly_load,
   input  logic                    active,
   output logic                    arr_next,
   output logic [SYMBOL_WIDTH+1:0] rd_word,
   output logic [DLY_WIDTH-1:0]    dly
);

   localparam int WORD_W = SYMBOL_WIDTH + 2;

   logic [WORD_W-1:0]    mem [MAX_SKEW];
   logic [DLY_WIDTH-1:0] offset_q;
   logic                 arrived_q;
   logic                 marker_in;
   logic [DLY_WIDTH:0]   rd_sum;
   logic [DLY_WIDTH-1:0] rd_addr;

   assign marker_in = wr_word[WORD_W-1];
   assign arr_next  = arrived_q | (rec_en & marker_in);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arrived_q <= 1'b0;
         offset_q  <= '0;
         dly       <= '0;
      end else if (soft_rst || clr) begin
         arrived_q <= 1'b0;
         offset_q  <= '0;
         dly       <= '0;
      end else begin
         if (rec_en && marker_in && !arrived_q) begin
            arrived_q <= 1'b1;
            offset_q  <= cnt;
         end
         // A lane arriving on the final cycle has not set arrived_q yet: delay 0.
         if (dly_load) dly <= (active && arrived_q) ? (cnt - offset_q) : '0;
      end
   end

   // Read address is (wr_ptr - dly) mod MAX_SKEW, valid for any MAX_SKEW.
   always_comb begin
      rd_sum = {1'b0, wr_ptr} - {1'b0, dly};
      if (wr_ptr < dly) rd_sum = rd_sum + (DLY_WIDTH+1)'(MAX_SKEW);
      rd_addr = rd_sum[DLY_WIDTH-1:0];
   end

   assign rd_word = (dly == '0) ? wr_word : mem[rd_addr];

endmodule

// File: rtl/rx_multilane_deskew.sv
// Multi-lane deskew: measures marker skew across active lanes, delays early
// lanes so all present the same symbol time, and keeps checking alignment.
module rx_multilane_deskew
   import rx_deskew_pkg::*;
#(
   parameter int NUM_LANES    = 16,
   parameter int SYMBOL_WIDTH = 8,
   parameter int MAX_SKEW     = 8,
   parameter int DLY_WIDTH    = dly_width(MAX_SKEW)
) (
   input  logic                              local_clk,
   input  logic                              local_rst,
   input  logic                              soft_rst,
   input  logic                              deskew_en,
   input  logic [NUM_LANES-1:0]              lane_mask,
   input  logic                              in_valid,
   input  logic [NUM_LANES*SYMBOL_WIDTH-1:0] in_data,
   input  logic [NUM_LANES-1:0]              in_sync,
   input  logic [NUM_LANES-1:0]              in_marker,
   output logic                              out_valid,
   output logic [NUM_LANES*SYMBOL_WIDTH-1:0] out_data,
   output logic [NUM_LANES-1:0]              out_sync,
   output logic                              aligned,
   output logic                              deskew_error,
   output logic [NUM_LANES*DLY_WIDTH-1:0]    lane_delay
);

   localparam int                   WORD_W  = SYMBOL_WIDTH + 2;
   localparam logic [DLY_WIDTH-1:0] PTR_MAX = DLY_WIDTH'(MAX_SKEW - 1);

   deskew_state_e                    state_q, state_d;
   logic [DLY_WIDTH-1:0]             wr_ptr_q;
   logic [DLY_WIDTH-1:0]             cnt_q;
   logic                             started_q;
   logic [NUM_LANES-1:0]             mask_q;
   logic [NUM_LANES-1:0]             arr_next;
   logic [NUM_LANES-1:0]             dmark;
   logic [NUM_LANES-1:0]             act_dmark;
   logic [NUM_LANES-1:0]             rd_sync;
   logic [NUM_LANES*SYMBOL_WIDTH-1:0] rd_data;
   logic [NUM_LANES*SYMBOL_WIDTH-1:0] data_mask;
   logic                             all_arrived;
   logic                             armed;
   logic                             mismatch;
   logic                             search_entry;
   logic                             dly_load;
   logic                             rec_en;
   logic                             out_en;
   logic                             aligned_d;
   logic                             error_d;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [WORD_W-1:0] rd_word;

      rx_deskew_lane_buf #(
         .SYMBOL_WIDTH (SYMBOL_WIDTH),
         .MAX_SKEW     (MAX_SKEW),
         .DLY_WIDTH    (DLY_WIDTH)
      ) u_buf (
         .clk      (local_clk),
         .rst_n    (local_rst),
         .soft_rst (soft_rst),
         .wr_en    (in_valid),
         .wr_ptr   (wr_ptr_q),
         .wr_word  ({in_marker[i], in_sync[i], in_data[i*SYMBOL_WIDTH +: SYMBOL_WIDTH]}),
         .clr      (search_entry),
         .rec_en   (rec_en & mask_q[i]),
         .cnt      (cnt_q),
         .dly_load (dly_load),
         .active   (mask_q[i]),
         .arr_next (arr_next[i]),
         .rd_word  (rd_word),
         .dly      (lane_delay[i*DLY_WIDTH +: DLY_WIDTH])
      );

      assign dmark[i]                                = rd_word[WORD_W-1];
      assign rd_sync[i]                              = rd_word[SYMBOL_WIDTH];
      assign rd_data[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] = rd_word[SYMBOL_WIDTH-1:0];
      assign data_mask[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] = {SYMBOL_WIDTH{mask_q[i]}};
   end

   // Masked lanes count as already arrived and never take part in the check.
   assign all_arrived = &(arr_next | ~mask_q);
   assign armed       = started_q | (|(in_marker & mask_q));
   assign act_dmark   = dmark & mask_q;
   assign mismatch    = (|act_dmark) && (act_dmark != mask_q);

   always_ff @(posedge local_clk or negedge local_rst) begin
      if (!local_rst)   state_q <= IDLE;
      else if (soft_rst) state_q <= IDLE;
      else               state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (deskew_en) state_d = SEARCH;
         end
         SEARCH: begin
            if (!deskew_en)                               state_d = IDLE;
            else if (in_valid && armed && all_arrived)    state_d = ALIGNED;
            else if (in_valid && started_q && cnt_q == PTR_MAX) state_d = ERROR;
         end
         ALIGNED: begin
            if (!deskew_en)               state_d = IDLE;
            else if (in_valid && mismatch) state_d = ERROR;
         end
         ERROR: begin
            state_d = deskew_en ? SEARCH : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      search_entry = (state_q != SEARCH) && (state_d == SEARCH);
      dly_load     = (state_q == SEARCH) && (state_d == ALIGNED);
      rec_en       = (state_q == SEARCH) && in_valid;
      out_en       = (state_q == ALIGNED) && in_valid;
      aligned_d    = (state_d == ALIGNED);
      error_d      = (state_d == ERROR);
   end

   // Write pointer runs in every state; skew counter runs only once armed.
   always_ff @(posedge local_clk or negedge local_rst) begin
      if (!local_rst) begin
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         started_q <= 1'b0;
         mask_q    <= '0;
      end else if (soft_rst) begin
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         started_q <= 1'b0;
         mask_q    <= '0;
      end else begin
         if (in_valid) wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + DLY_WIDTH'(1);
         if (search_entry) begin
            cnt_q     <= '0;
            started_q <= 1'b0;
            mask_q    <= lane_mask;
         end else if (rec_en && armed) begin
            started_q <= 1'b1;
            cnt_q     <= cnt_q + DLY_WIDTH'(1);
         end
      end
   end

   // Output stage
   always_ff @(posedge local_clk or negedge local_rst) begin
      if (!local_rst) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_sync     <= '0;
         aligned      <= 1'b0;
         deskew_error <= 1'b0;
      end else if (soft_rst) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_sync     <= '0;
         aligned      <= 1'b0;
         deskew_error <= 1'b0;
      end else begin
         out_valid    <= out_en;
         out_data     <= out_en ? (rd_data & data_mask) : '0;
         out_sync     <= out_en ? (rd_sync & mask_q) : '0;
         aligned      <= aligned_d;
         deskew_error <= error_d;
      end
   end

endmodule

// File: tb/tb_rx_multilane_deskew.sv
// Directed bench for rx_multilane_deskew with 4 lanes and an 8-deep skew buffer.
module tb_rx_multilane_deskew;

   localparam int NL = 4;
   localparam int SW = 8;
   localparam int MS = 8;
   localparam int DW = 3;

   logic              local_clk = 1'b0;
   logic              local_rst = 1'b0;
   logic              soft_rst  = 1'b0;
   logic              deskew_en = 1'b0;
   logic [NL-1:0]     lane_mask = 4'hF;
   logic              in_valid  = 1'b0;
   logic [NL*SW-1:0]  in_data   = '0;
   logic [NL-1:0]     in_sync   = '0;
   logic [NL-1:0]     in_marker = '0;
   logic              out_valid;
   logic [NL*SW-1:0]  out_data;
   logic [NL-1:0]     out_sync;
   logic              aligned;
   logic              deskew_error;
   logic [NL*DW-1:0]  lane_delay;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 local_clk = ~local_clk;

   rx_multilane_deskew #(
      .NUM_LANES    (NL),
      .SYMBOL_WIDTH (SW),
      .MAX_SKEW     (MS)
   ) dut (
      .local_clk    (local_clk),
      .local_rst    (local_rst),
      .soft_rst     (soft_rst),
      .deskew_en    (deskew_en),
      .lane_mask    (lane_mask),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_sync      (in_sync),
      .in_marker    (in_marker),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_sync     (out_sync),
      .aligned      (aligned),
      .deskew_error (deskew_error),
      .lane_delay   (lane_delay)
   );

   // Lane i symbol at step j is {j, i}; marker symbols are 8'hBC.
   function automatic logic [31:0] mkdata(input int j, input logic [3:0] mk);
      logic [31:0] d;
      d = '0;
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = mk[i] ? 8'hBC : {4'(j), 4'(i)};
      return d;
   endfunction

   function automatic logic [3:0] lsbs(input logic [31:0] d);
      return {d[24], d[16], d[8], d[0]};
   endfunction

   task automatic cyc(input logic v, input int j, input logic [3:0] mk);
      in_valid  = v;
      in_marker = mk;
      in_data   = mkdata(j, mk);
      in_sync   = lsbs(in_data);
      @(posedge local_clk);
      #1;
   endtask

   task automatic enter_search(input logic [3:0] mask);
      deskew_en = 1'b0;
      cyc(1'b1, 15, 4'h0);
      lane_mask = mask;
      deskew_en = 1'b1;
      cyc(1'b1, 15, 4'h0);
   endtask

   task automatic test_reset;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL rst_aligned: got %b want 0", aligned); end
      n_cmp++; if (deskew_error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", deskew_error); end
      n_cmp++; if (lane_delay !== 12'h000) begin n_bad++; $display("FAIL rst_lane_delay: got %h want 000", lane_delay); end
      n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      n_cmp++; if (out_sync !== 4'h0) begin n_bad++; $display("FAIL rst_out_sync: got %h want 0", out_sync); end
      local_rst = 1'b1;
      cyc(1'b1, 14, 4'hF);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_zero_skew;
      enter_search(4'hF);
      cyc(1'b1, 1, 4'hF);
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL zs_aligned: got %b want 1", aligned); end
      n_cmp++; if (lane_delay !== 12'h000) begin n_bad++; $display("FAIL zs_delay: got %h want 000", lane_delay); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL zs_first_valid: got %b want 0", out_valid); end
      cyc(1'b1, 2, 4'h0);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL zs_out_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_data !== 32'h23222120) begin n_bad++; $display("FAIL zs_data2: got %h want 23222120", out_data); end
      n_cmp++; if (out_sync !== 4'hA) begin n_bad++; $display("FAIL zs_sync2: got %h want a", out_sync); end
      cyc(1'b1, 3, 4'h0);
      n_cmp++; if (out_data !== 32'h33323130) begin n_bad++; $display("FAIL zs_data3: got %h want 33323130", out_data); end
   endtask

   task automatic test_skew;
      logic [3:0] mk_seq [6];
      mk_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b1000, 4'b0000, 4'b0100};
      enter_search(4'hF);
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, k, mk_seq[k]);
         if (k == 4) begin
            n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL sk_early_aligned: got %b want 0", aligned); end
         end
      end
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL sk_aligned: got %b want 1", aligned); end
      n_cmp++; if (lane_delay !== 12'h41D) begin n_bad++; $display("FAIL sk_delay: got %h want 41d", lane_delay); end
      for (int j = 0; j < 6; j++) cyc(1'b1, j, mk_seq[j]);
      n_cmp++; if (out_data !== 32'hBCBCBCBC) begin n_bad++; $display("FAIL sk_markers: got %h want bcbcbcbc", out_data); end
      n_cmp++; if (deskew_error !== 1'b0) begin n_bad++; $display("FAIL sk_no_error: got %b want 0", deskew_error); end
      cyc(1'b1, 6, 4'h0);
      n_cmp++; if (out_data !== 32'h43623110) begin n_bad++; $display("FAIL sk_data6: got %h want 43623110", out_data); end
      n_cmp++; if (out_sync !== 4'hA) begin n_bad++; $display("FAIL sk_sync6: got %h want a", out_sync); end
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL sk_hold: got %b want 1", aligned); end
   endtask

   task automatic test_overflow;
      enter_search(4'hF);
      cyc(1'b1, 0, 4'b1011);
      for (int j = 1; j < 7; j++) cyc(1'b1, j, 4'h0);
      n_cmp++; if (deskew_error !== 1'b0) begin n_bad++; $display("FAIL ov_early_error: got %b want 0", deskew_error); end
      cyc(1'b1, 7, 4'h0);
      n_cmp++; if (deskew_error !== 1'b1) begin n_bad++; $display("FAIL ov_error: got %b want 1", deskew_error); end
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL ov_aligned: got %b want 0", aligned); end
      cyc(1'b1, 8, 4'b0100);
      n_cmp++; if (deskew_error !== 1'b0) begin n_bad++; $display("FAIL ov_pulse: got %b want 0", deskew_error); end
      cyc(1'b1, 9, 4'b1011);
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL ov_re_early: got %b want 0", aligned); end
      cyc(1'b1, 10, 4'b0100);
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL ov_re_aligned: got %b want 1", aligned); end
      n_cmp++; if (lane_delay !== 12'h209) begin n_bad++; $display("FAIL ov_re_delay: got %h want 209", lane_delay); end
   endtask

   task automatic test_lane_mask;
      enter_search(4'b0011);
      cyc(1'b1, 0, 4'b0001);
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL lm_early: got %b want 0", aligned); end
      cyc(1'b1, 1, 4'b0010);
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL lm_aligned: got %b want 1", aligned); end
      n_cmp++; if (lane_delay !== 12'h001) begin n_bad++; $display("FAIL lm_delay: got %h want 001", lane_delay); end
      cyc(1'b1, 2, 4'h0);
      n_cmp++; if (out_data !== 32'h00002110) begin n_bad++; $display("FAIL lm_data: got %h want 00002110", out_data); end
      n_cmp++; if (out_sync !== 4'b0010) begin n_bad++; $display("FAIL lm_sync: got %b want 0010", out_sync); end
   endtask

   task automatic test_align_loss;
      enter_search(4'hF);
      cyc(1'b1, 0, 4'hF);
      cyc(1'b1, 1, 4'h0);
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL al_aligned: got %b want 1", aligned); end
      cyc(1'b1, 2, 4'b1101);
      n_cmp++; if (deskew_error !== 1'b1) begin n_bad++; $display("FAIL al_error: got %b want 1", deskew_error); end
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL al_dropped: got %b want 0", aligned); end
      cyc(1'b1, 3, 4'b0010);
      n_cmp++; if (deskew_error !== 1'b0) begin n_bad++; $display("FAIL al_pulse: got %b want 0", deskew_error); end
      cyc(1'b1, 4, 4'hF);
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL al_research: got %b want 1", aligned); end
      n_cmp++; if (lane_delay !== 12'h000) begin n_bad++; $display("FAIL al_delay: got %h want 000", lane_delay); end
   endtask

   task automatic test_gapped_valid;
      enter_search(4'hF);
      cyc(1'b1, 0, 4'b0111);
      cyc(1'b0, 15, 4'h0);
      cyc(1'b0, 15, 4'h0);
      cyc(1'b1, 1, 4'h0);
      cyc(1'b0, 15, 4'b1000);
      cyc(1'b0, 15, 4'h0);
      cyc(1'b1, 2, 4'h0);
      cyc(1'b0, 15, 4'h0);
      cyc(1'b0, 15, 4'h0);
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL gv_early: got %b want 0", aligned); end
      cyc(1'b1, 3, 4'b1000);
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL gv_aligned: got %b want 1", aligned); end
      n_cmp++; if (lane_delay !== 12'h0DB) begin n_bad++; $display("FAIL gv_delay: got %h want 0db", lane_delay); end
      cyc(1'b0, 15, 4'h0);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL gv_gap_valid: got %b want 0", out_valid); end
      cyc(1'b1, 4, 4'h0);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL gv_out_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_data !== 32'h43121110) begin n_bad++; $display("FAIL gv_data: got %h want 43121110", out_data); end
   endtask

   task automatic test_soft_rst;
      soft_rst = 1'b1;
      cyc(1'b1, 5, 4'h0);
      soft_rst = 1'b0;
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL sr_aligned: got %b want 0", aligned); end
      n_cmp++; if (lane_delay !== 12'h000) begin n_bad++; $display("FAIL sr_delay: got %h want 000", lane_delay); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sr_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL sr_out_data: got %h want 0", out_data); end
   endtask

   task automatic test_async_rst;
      deskew_en = 1'b1;
      cyc(1'b1, 15, 4'h0);
      cyc(1'b1, 0, 4'b0001);
      #2 local_rst = 1'b0;
      #1;
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL ar_search_aligned: got %b want 0", aligned); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_search_valid: got %b want 0", out_valid); end
      @(posedge local_clk);
      #1 local_rst = 1'b1;
      cyc(1'b1, 1, 4'hF);
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL ar_idle_state: got %b want 0", aligned); end
      cyc(1'b1, 2, 4'hF);
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL ar_realign: got %b want 1", aligned); end
      cyc(1'b1, 3, 4'h0);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ar_running: got %b want 1", out_valid); end
      #2 local_rst = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_async_valid: got %b want 0", out_valid); end
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL ar_async_aligned: got %b want 0", aligned); end
      n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL ar_async_data: got %h want 0", out_data); end
   endtask

   initial begin
      repeat (3) @(posedge local_clk);
      #1;
      test_reset();
      test_zero_skew();
      test_skew();
      test_overflow();
      test_lane_mask();
      test_align_loss();
      test_gapped_valid();
      test_soft_rst();
      test_async_rst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
